// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: size codes, FSM states, lane helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       uns;
   } req_ctl_t;

   function automatic logic [7:0] be_mask(input logic [1:0] size);
      case (size)
         SZ_B:    be_mask = 8'h01;
         SZ_H:    be_mask = 8'h03;
         SZ_W:    be_mask = 8'h0F;
         default: be_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
      case (size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = lo[0];
         SZ_W:    misaligned = (lo[1:0] != 2'b00);
         default: misaligned = (lo != 3'b000);
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shift the bus word down to the addressed lane, then
// truncate to the access size and sign/zero-extend; zero latency, no flow control.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]           i_data,
   input  logic [$clog2(DATA_W/8)-1:0] i_lane,
   input  logic [1:0]                  i_size,
   input  logic                        i_unsigned,
   output logic [DATA_W-1:0]           o_data
);

   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] w_keep;
   logic              w_sign;

   assign w_shifted = i_data >> {i_lane, 3'b000};

   always_comb begin
      w_keep = '1;
      w_sign = 1'b0;
      case (i_size)
         SZ_B: begin
            w_keep = DATA_W'(8'hFF);
            w_sign = w_shifted[7];
         end
         SZ_H: begin
            w_keep = DATA_W'(16'hFFFF);
            w_sign = w_shifted[15];
         end
         SZ_W: begin
            w_keep = DATA_W'(32'hFFFF_FFFF);
            w_sign = w_shifted[31];
         end
         default: begin
            w_keep = '1;
            w_sign = 1'b0;
         end
      endcase
   end

   // A full-width word leaves ~w_keep at zero, so it passes through untouched.
   assign o_data = (w_shifted & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit driving the bus bridge with byte enables, lane replication and timeout.
// Latency 2 + wait states (1 for misaligned); req_ready only in IDLE, one request in flight.
module lsu_bus_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                cpu_clk,
   input  logic                cpu_rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                busy,
   output logic                Bus_req,
   output logic [ADDR_W-1:0]   Bus_addr,
   output logic                Bus_wen,
   output logic [DATA_W/8-1:0] Bus_be,
   output logic [DATA_W-1:0]   Bus_wdata,
   input  logic                Bus_ack,
   input  logic [DATA_W-1:0]   Bus_rdata
);

   localparam int BE_W  = DATA_W / 8;
   localparam int LN_W  = $clog2(BE_W);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            r_state;
   state_t            w_next;
   req_ctl_t          r_ctl;
   logic [ADDR_W-1:0] r_addr;
   logic [LN_W-1:0]   r_lane;
   logic [BE_W-1:0]   r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   logic [LN_W-1:0]   w_lane;
   logic [7:0]        w_mask8;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;
   logic              w_bad;
   logic              w_timeout;
   logic [DATA_W-1:0] w_ld;

   assign w_lane    = req_addr[LN_W-1:0];
   assign w_mask8   = be_mask(req_size);
   assign w_be      = BE_W'(w_mask8) << w_lane;
   assign w_bad     = misaligned(req_size, req_addr[2:0]) || ((DATA_W == 32) && (req_size == SZ_D));
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   always_comb begin
      w_wdata = req_wdata;
      case (req_size)
         SZ_B:    w_wdata = {BE_W{req_wdata[7:0]}};
         SZ_H:    w_wdata = {(DATA_W/16){req_wdata[15:0]}};
         SZ_W:    w_wdata = {(DATA_W/32){req_wdata[31:0]}};
         default: w_wdata = req_wdata;
      endcase
   end

   lsu_load_align #(.DATA_W(DATA_W)) u_align (
      .i_data     (r_rdata),
      .i_lane     (r_lane),
      .i_size     (r_ctl.size),
      .i_unsigned (r_ctl.uns),
      .o_data     (w_ld)
   );

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         r_state <= ST_IDLE;
         r_ctl   <= '0;
         r_addr  <= '0;
         r_lane  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_ctl   <= '{we: req_we, size: req_size, uns: req_unsigned};
                  r_addr  <= {req_addr[ADDR_W-1:LN_W], {LN_W{1'b0}}};
                  r_lane  <= w_lane;
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_err   <= w_bad;
                  r_rdata <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_BUS: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // Ack beats a timeout landing in the same cycle.
               if (Bus_ack) begin
                  r_rdata <= Bus_rdata;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      Bus_req    = 1'b0;
      Bus_wen    = 1'b0;
      Bus_addr   = '0;
      Bus_be     = '0;
      Bus_wdata  = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) w_next = w_bad ? ST_RESP : ST_BUS;
         end
         ST_BUS: begin
            Bus_req   = 1'b1;
            Bus_wen   = r_ctl.we;
            Bus_addr  = r_addr;
            Bus_be    = r_be;
            Bus_wdata = r_wdata;
            if (Bus_ack || w_timeout) w_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            resp_rdata = (!r_ctl.we && !r_err) ? w_ld : '0;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: vector table with response scoreboard, plus reset and 64-bit sequences.
module tb_lsu_bus_master;

   logic        clk = 1'b0;
   logic        cpu_rst;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;
   logic        Bus_req, Bus_wen, Bus_ack;
   logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
   logic [3:0]  Bus_be;

   logic        v64, rdy64, rv64, err64, busy64, breq64, bwen64, back64;
   logic [1:0]  sz64;
   logic [31:0] a64, baddr64;
   logic [63:0] rdata64, bwdata64, brdata64;
   logic [7:0]  bbe64;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_bus_master dut (
      .cpu_clk(clk), .cpu_rst(cpu_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
      .Bus_req(Bus_req), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_be(Bus_be),
      .Bus_wdata(Bus_wdata), .Bus_ack(Bus_ack), .Bus_rdata(Bus_rdata)
   );

   lsu_bus_master #(.DATA_W(64)) dut64 (
      .cpu_clk(clk), .cpu_rst(cpu_rst),
      .req_valid(v64), .req_ready(rdy64), .req_we(1'b0), .req_size(sz64),
      .req_unsigned(1'b0), .req_addr(a64), .req_wdata(64'h0),
      .resp_valid(rv64), .resp_rdata(rdata64), .resp_err(err64), .busy(busy64),
      .Bus_req(breq64), .Bus_addr(baddr64), .Bus_wen(bwen64), .Bus_be(bbe64),
      .Bus_wdata(bwdata64), .Bus_ack(back64), .Bus_rdata(brdata64)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_cyc;   // BUS cycle (1-based) carrying the ack; 0 = never
      logic [31:0] brdata;
      int          nbus;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   vec_t vecs[13];
   exp_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (cpu_rst && resp_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_resp: resp_valid=1 with no access outstanding (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", resp_err, e.err);
            chk("resp_cycle", cyc, e.due);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int nb;
      int c0;
      @(negedge clk);
      chk("req_ready", req_ready, 1'b1);
      req_valid    = 1'b1;
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      c0 = cyc;
      q.push_back('{rdata: v.rdata, err: v.err, due: c0 + v.lat});
      nb = 0;
      for (int k = 1; k <= v.lat + 1; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         Bus_ack   = 1'b0;
         if (Bus_req) begin
            nb++;
            if (nb == 1) begin
               chk("bus_be", Bus_be, v.be);
               chk("bus_wdata", Bus_wdata, v.bwdata);
               chk("bus_wen", Bus_wen, v.we);
               chk("bus_addr", Bus_addr, {v.addr[31:2], 2'b00});
            end
            if (nb == v.ack_cyc) begin
               Bus_ack   = 1'b1;
               Bus_rdata = v.brdata;
            end
         end
      end
      chk("bus_cycles", nb, v.nbus);
   endtask

   task automatic run64(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] rd,
                        input logic [7:0] be, input logic [63:0] exp, input logic err);
      @(negedge clk);
      v64  = 1'b1;
      sz64 = sz;
      a64  = a;
      @(negedge clk);
      v64 = 1'b0;
      if (err) begin
         chk("bus_req64_err", breq64, 1'b0);
         chk("resp_valid64_err", rv64, 1'b1);
         chk("resp_err64", err64, 1'b1);
         chk("resp_rdata64_err", rdata64, 64'h0);
      end else begin
         chk("bus_req64", breq64, 1'b1);
         chk("bus_be64", bbe64, be);
         chk("bus_addr64", baddr64, {a[31:3], 3'b000});
         back64   = 1'b1;
         brdata64 = rd;
         @(negedge clk);
         back64 = 1'b0;
         chk("resp_valid64", rv64, 1'b1);
         chk("resp_err64", err64, 1'b0);
         chk("resp_rdata64", rdata64, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      cpu_rst = 1'b0;
      req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
      Bus_ack = 0; Bus_rdata = 0;
      v64 = 0; sz64 = 0; a64 = 0; back64 = 0; brdata64 = 0;

      //          we   sz    uns   addr          wdata         ack brdata        nbus be       bwdata        rdata         err  lat
      vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 2};
      vecs[1]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,         3, 32'h8001_1234, 3, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 4};
      vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0,         3, 32'h8001_1234, 3, 4'b1100, 32'h0,         32'h0000_8001, 1'b0, 4};
      vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0,         0, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1, 1};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,         0, 32'h1111_1111, 15, 4'b1111, 32'h0,        32'h0,         1'b1, 16};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'h0,         15, 32'hDEAD_BEEF, 15, 4'b1111, 32'h0,       32'hDEAD_BEEF, 1'b0, 16};
      vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h0000_5000, 32'h0,         0, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1, 1};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_6002, 32'h1234_BEEF, 2, 32'h5555_5555, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 3};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h0000_7001, 32'h0,         1, 32'h0000_8000, 1, 4'b0010, 32'h0,         32'hFFFF_FF80, 1'b0, 2};
      vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h0000_7002, 32'h0,         2, 32'h00AB_0000, 2, 4'b0100, 32'h0,         32'h0000_00AB, 1'b0, 3};
      vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_8000, 32'hCAFE_F00D, 1, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0, 2};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_9001, 32'h0000_1234, 0, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1, 1};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h0000_7000, 32'h0,         1, 32'h1234_F00F, 1, 4'b0011, 32'h0,         32'hFFFF_F00F, 1'b0, 2};

      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bus_req", Bus_req, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_bus_be", Bus_be, 4'h0);
      chk("rst_req_ready64", rdy64, 1'b1);
      cpu_rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in the middle of a bus cycle: bus and busy drop at once, no response follows.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_A000;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_bus_req", Bus_req, 1'b1);
      chk("pre_rst_busy", busy, 1'b1);
      cpu_rst = 1'b0;
      #1;
      chk("mid_rst_bus_req", Bus_req, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      cpu_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1'b1);

      // Timeout after a reset must again allow exactly 15 bus cycles.
      run_vec(vecs[4]);

      run64(2'd3, 32'h0000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
      run64(2'd1, 32'h0000_001A, 64'h0123_4567_89AB_CDEF, 8'h0C, 64'hFFFF_FFFF_FFFF_89AB, 1'b0);
      run64(2'd3, 32'h0000_0014, 64'h0,                   8'h00, 64'h0,                   1'b1);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
